// File: rtl/h264_nalparse.sv
`default_nettype none
// ---------------------------------------------------------------------------
// h264_nalparse : Annex B start-code search, emulation-prevention removal and
//                 NAL framing. Optional counters: H264_NALPARSE_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module h264_nalparse
`ifdef H264_NALPARSE_STATS_EN
#(
   parameter int CNTBITS = 16
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] BYTE,
   input  logic       STROBE,
   output logic       READY,
   input  logic       EOS,
   output logic [7:0] NAL_BYTE,
   output logic       NAL_VALID,
   input  logic       NAL_READY,
   output logic       NAL_START,
   output logic       NAL_END,
   output logic [4:0] NAL_TYPE,
   output logic [1:0] NAL_REFIDC,
   output logic       ERR
`ifdef H264_NALPARSE_STATS_EN
   ,
   output logic [CNTBITS-1:0] nal_count,
   output logic [CNTBITS-1:0] epb_count
`endif
);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_ZFLUSH  = 2'd3
   } state_t;

   state_t     state;
   logic [1:0] zcnt;
   logic [1:0] zleft;
   logic       trail;
   logic [7:0] trail_byte;
   logic [7:0] held_byte;
   logic       held_valid;
   logic       held_start;

   logic       out_free, acc_byte, acc_eos;
   logic       is00, is01, is02, is03;
   logic [1:0] zinc;
   logic       pl_end, pl_epb, pl_err, pl_push;
   logic       push_en, push_start, term_en, err_set, out_load;
   logic [7:0] push_val;

   assign out_free = !NAL_VALID || NAL_READY;
   assign READY    = (state != S_ZFLUSH) && out_free;
   assign acc_eos  = EOS && READY;
   assign acc_byte = STROBE && READY && !EOS;

   assign is00 = (BYTE == 8'h00);
   assign is01 = (BYTE == 8'h01);
   assign is02 = (BYTE == 8'h02);
   assign is03 = (BYTE == 8'h03);
   assign zinc = (zcnt == 2'd3) ? 2'd3 : zcnt + 2'd1;

   // Payload byte classification against the pending-zero count
   assign pl_end  = is01 && zcnt[1];
   assign pl_epb  = is03 && (zcnt == 2'd2);
   assign pl_err  = (is02 && zcnt[1]) || ((zcnt == 2'd3) && !is00 && !is01);
   assign pl_push = (zcnt == 2'd0) && !is00;

   assign push_en = (state == S_HEADER  && acc_byte && !BYTE[7]) ||
                    (state == S_PAYLOAD && acc_byte && pl_push) ||
                    (state == S_ZFLUSH  && out_free);
   assign push_val   = (state == S_ZFLUSH) ? ((zleft != 2'd0) ? 8'h00 : trail_byte) : BYTE;
   assign push_start = (state == S_HEADER);
   assign term_en    = (state == S_PAYLOAD) && (acc_eos || (acc_byte && (pl_end || pl_err)));
   assign err_set    = acc_byte && ((state == S_HEADER && BYTE[7]) ||
                                    (state == S_PAYLOAD && pl_err));
   assign out_load   = held_valid && (push_en || term_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_SEARCH;
         zcnt       <= 2'd0;
         zleft      <= 2'd0;
         trail      <= 1'b0;
         trail_byte <= 8'h00;
      end else begin
         case (state)
            S_SEARCH: begin
               if (acc_byte) begin
                  if (is00) begin
                     zcnt <= zinc;
                  end else if (is01 && zcnt[1]) begin
                     state <= S_HEADER;
                     zcnt  <= 2'd0;
                  end else begin
                     zcnt <= 2'd0;
                  end
               end
            end
            S_HEADER: begin
               if (acc_eos || (acc_byte && BYTE[7])) begin
                  state <= S_SEARCH;
               end else if (acc_byte) begin
                  state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (acc_eos) begin
                  state <= S_SEARCH;
                  zcnt  <= 2'd0;
               end else if (acc_byte) begin
                  if (is00) begin
                     zcnt <= zinc;
                  end else if (pl_end) begin
                     state <= S_HEADER;
                     zcnt  <= 2'd0;
                  end else if (pl_epb) begin
                     state <= S_ZFLUSH;
                     zleft <= 2'd2;
                     trail <= 1'b0;
                     zcnt  <= 2'd0;
                  end else if (pl_err) begin
                     state <= S_SEARCH;
                     zcnt  <= 2'd0;
                  end else if (!pl_push) begin
                     state      <= S_ZFLUSH;
                     zleft      <= zcnt;
                     trail      <= 1'b1;
                     trail_byte <= BYTE;
                     zcnt       <= 2'd0;
                  end
               end
            end
            S_ZFLUSH: begin
               if (out_free) begin
                  if (zleft != 2'd0) begin
                     zleft <= zleft - 2'd1;
                     if (zleft == 2'd1 && !trail) begin
                        state <= S_PAYLOAD;
                     end
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end
            end
            default: state <= S_SEARCH;
         endcase
      end
   end

   // One-byte lookahead: the held byte only reaches the output once its successor (or end) is known
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         NAL_BYTE   <= 8'h00;
         NAL_VALID  <= 1'b0;
         NAL_START  <= 1'b0;
         NAL_END    <= 1'b0;
         NAL_TYPE   <= 5'd0;
         NAL_REFIDC <= 2'd0;
         ERR        <= 1'b0;
         held_byte  <= 8'h00;
         held_valid <= 1'b0;
         held_start <= 1'b0;
      end else begin
         ERR <= err_set;
         if (out_load) begin
            NAL_BYTE  <= held_byte;
            NAL_VALID <= 1'b1;
            NAL_START <= held_start;
            NAL_END   <= term_en;
            if (held_start) begin
               NAL_TYPE   <= held_byte[4:0];
               NAL_REFIDC <= held_byte[6:5];
            end
         end else if (NAL_READY) begin
            NAL_VALID <= 1'b0;
         end
         if (push_en) begin
            held_byte  <= push_val;
            held_valid <= 1'b1;
            held_start <= push_start;
         end else if (term_en) begin
            held_valid <= 1'b0;
            held_start <= 1'b0;
         end
      end
   end

`ifdef H264_NALPARSE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nal_count <= '0;
         epb_count <= '0;
      end else begin
         if (NAL_VALID && NAL_READY && NAL_END) begin
            nal_count <= nal_count + 1'b1;
         end
         if (state == S_PAYLOAD && acc_byte && pl_epb) begin
            epb_count <= epb_count + 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264_nalparse.sv
`default_nettype none
// tb_h264_nalparse: directed Annex B streams against hand-computed NAL output.
module tb_h264_nalparse;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] BYTE;
   logic       STROBE;
   logic       READY;
   logic       EOS;
   logic [7:0] NAL_BYTE;
   logic       NAL_VALID;
   logic       NAL_READY;
   logic       NAL_START;
   logic       NAL_END;
   logic [4:0] NAL_TYPE;
   logic [1:0] NAL_REFIDC;
   logic       ERR;
`ifdef H264_NALPARSE_STATS_EN
   logic [15:0] nal_count;
   logic [15:0] epb_count;
`endif

   int errors = 0;
   int checks = 0;
   int err_seen = 0;
   int rdy_mode = 0;
   bit gap_en = 1'b0;
   int e0;
   logic [16:0] gq[$];
   logic [16:0] eq[$];
   logic        stall_prev = 1'b0;
   logic [17:0] prev_out = '0;

   always #5 clk = ~clk;

   h264_nalparse dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .BYTE       (BYTE),
      .STROBE     (STROBE),
      .READY      (READY),
      .EOS        (EOS),
      .NAL_BYTE   (NAL_BYTE),
      .NAL_VALID  (NAL_VALID),
      .NAL_READY  (NAL_READY),
      .NAL_START  (NAL_START),
      .NAL_END    (NAL_END),
      .NAL_TYPE   (NAL_TYPE),
      .NAL_REFIDC (NAL_REFIDC),
      .ERR        (ERR)
`ifdef H264_NALPARSE_STATS_EN
      ,
      .nal_count  (nal_count),
      .epb_count  (epb_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: record transfers, count ERR pulses, verify outputs hold while stalled
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (NAL_VALID && NAL_READY)
            gq.push_back({NAL_START, NAL_END, NAL_TYPE, NAL_REFIDC, NAL_BYTE});
         if (ERR)
            err_seen <= err_seen + 1;
         if (stall_prev)
            check("hold", {14'd0, NAL_VALID, NAL_START, NAL_END, NAL_TYPE, NAL_REFIDC, NAL_BYTE},
                  {14'd0, prev_out});
         stall_prev <= NAL_VALID && !NAL_READY;
         prev_out   <= {NAL_VALID, NAL_START, NAL_END, NAL_TYPE, NAL_REFIDC, NAL_BYTE};
      end
   end

   initial begin
      NAL_READY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       NAL_READY = 1'b1;
            1:       NAL_READY = ~NAL_READY;
            default: NAL_READY = 1'b0;
         endcase
      end
   end

   task automatic put(input logic [7:0] b, input logic eos);
      int n;
      n = 0;
      if (gap_en) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      BYTE   = b;
      EOS    = eos;
      STROBE = 1'b1;
      @(negedge clk);
      while (!READY && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!READY) check("put_timeout", n, 0);
      @(posedge clk);
      #1;
      STROBE = 1'b0;
      EOS    = 1'b0;
   endtask

   task automatic send(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++) put(v[8*(n-1-i) +: 8], 1'b0);
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_nal(input logic [63:0] v, input int n);
      logic [7:0] h;
      h = v[8*(n-1) +: 8];
      for (int i = 0; i < n; i++)
         eq.push_back({(i == 0), (i == n-1), h[4:0], h[6:5], v[8*(n-1-i) +: 8]});
   endtask

   task automatic compare(input string tag);
      check({tag, "_len"}, gq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++)
         check($sformatf("%s_%0d", tag, i), (i < gq.size()) ? {15'd0, gq[i]} : 32'hFFFF_FFFF,
               {15'd0, eq[i]});
      gq.delete();
      eq.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      BYTE   = 8'h00;
      STROBE = 1'b0;
      EOS    = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", READY, 1);
      check("rst_valid", NAL_VALID, 0);
      check("rst_start", NAL_START, 0);
      check("rst_end", NAL_END, 0);
      check("rst_type", NAL_TYPE, 0);
      check("rst_refidc", NAL_REFIDC, 0);
      check("rst_err", ERR, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two NALs, 4-byte start codes, leading junk, trailing start code then EOS
      e0 = err_seen;
      send(128'hAA_00_00_00_01_67_42_00_28_DA_05_82_59, 13);
      send(128'h00_00_00_01_68_CE_38_80_00_00_00_01, 12);
      put(8'h00, 1'b1);
      drain(12);
      exp_nal(64'h67_42_00_28_DA_05_82_59, 8);
      exp_nal(64'h68_CE_38_80, 4);
      compare("t1");
      check("t1_err", err_seen - e0, 0);

      // Emulation-prevention removal
      send(128'h00_00_01_65_11_00_00_03_00_22_00_00_01, 13);
      put(8'h00, 1'b1);
      drain(12);
      exp_nal(64'h65_11_00_00_00_22, 6);
      compare("t2");
`ifdef H264_NALPARSE_STATS_EN
      check("t2_epb", epb_count, 1);
      check("t2_nal", nal_count, 3);
`endif

      // Same stream under output backpressure and gappy input
      rdy_mode = 1;
      gap_en   = 1'b1;
      send(128'h00_00_01_65_11_00_00_03_00_22_00_00_01, 13);
      put(8'h00, 1'b1);
      drain(24);
      exp_nal(64'h65_11_00_00_00_22, 6);
      compare("t3");
      rdy_mode = 0;
      gap_en   = 1'b0;
      drain(2);

      // Forbidden bit, then 00 00 02 error with END, then resync
      e0 = err_seen;
      send(128'h00_00_01_E5, 4);
      send(128'h00_00_01_41_00_00_02, 7);
      send(128'h00_00_01_21_5A, 5);
      put(8'h00, 1'b1);
      drain(12);
      exp_nal(64'h41, 1);
      exp_nal(64'h21_5A, 2);
      compare("t4");
      check("t4_err", err_seen - e0, 2);

      // Header-only NAL
      send(128'h00_00_01_09, 4);
      put(8'h00, 1'b1);
      drain(12);
      exp_nal(64'h09, 1);
      compare("t5");

      // Asynchronous reset in the middle of a NAL
      rdy_mode = 2;
      drain(2);
      send(128'h00_00_01_41_77, 5);
      drain(1);
      check("t6_pre_valid", NAL_VALID, 1);
      check("t6_pre_byte", NAL_BYTE, 8'h41);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", NAL_VALID, 0);
      check("t6_async_ready", READY, 1);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rdy_mode = 0;
      drain(2);
      send(128'h00_00_01_06_AB, 5);
      put(8'h00, 1'b1);
      drain(12);
      exp_nal(64'h06_AB, 2);
      compare("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
